cuckoo_lookup_sched: RTL and testbench

// Shares one Cuckoo_L6-style lookup engine (hash -> T1/T2 RAM -> T3 RAM -> compare)

---
 rtl/cuckoo_lookup_sched.sv | 176 +++++++++++++++++
 tb/tb_cuckoo_lookup_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cuckoo_lookup_sched.sv
`default_nettype none
// ============================================================================
// Module      : cuckoo_lookup_sched
// Description : Round-robin scheduler sharing one fixed-latency cuckoo lookup
//               engine among NUM_REQ lanes. Results are returned in issue
//               order through a credit-protected response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module cuckoo_lookup_sched #(
   parameter int NUM_REQ   = 4,
   parameter int WIN_W     = 160,
   parameter int LAT       = 4,
   parameter int CMP_DLY   = 3,
   parameter int RSP_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*20-1:0]        req_prehash,
   input  logic [NUM_REQ*WIN_W-1:0]     req_window,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         eng_enable,
   output logic [9:0]                   eng_prehash_t1,
   output logic [9:0]                   eng_prehash_t2,
   output logic [WIN_W-1:0]             eng_fifo_in,
   input  logic [1:0]                   eng_compare_out,
   input  logic [1:0]                   eng_suffix,
   output logic                         rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_lane,
   output logic [1:0]                   rsp_match,
   output logic [1:0]                   rsp_suffix,
   input  logic                         rsp_ready
);

   localparam int c_lane_w = $clog2(NUM_REQ);
   localparam int c_ptr_w  = $clog2(RSP_DEPTH);
   localparam int c_cnt_w  = c_ptr_w + 1;
   localparam int c_ent_w  = c_lane_w + 4;
   // Bits [79:32] of the engine window are consumed late, in the compare stage.
   localparam logic [WIN_W-1:0] c_cmp_mask = {{(WIN_W-48){1'b0}}, {48{1'b1}}} << 32;

   logic [c_lane_w-1:0] r_ptr;
   logic [LAT-1:0]      r_trk_vld;
   logic [c_lane_w-1:0] r_trk_lane [LAT];
   logic [47:0]         r_cmp_dly  [CMP_DLY];
   logic [c_ent_w-1:0]  r_mem      [RSP_DEPTH];
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [c_cnt_w-1:0]  r_count;

   int                  w_inflight;
   int                  w_idx;
   logic                w_can_issue;
   logic                w_found;
   logic [c_lane_w-1:0] w_gidx;
   logic [WIN_W-1:0]    w_win;
   logic [47:0]         w_cmp_out;
   logic                w_push;
   logic                w_pop;
   logic [c_ent_w-1:0]  w_head;

   // Count lookups still travelling through the engine; they hold FIFO credits.
   always_comb begin
      w_inflight = 0;
      for (int i = 0; i < LAT; i++) begin
         w_inflight = w_inflight + int'(r_trk_vld[i]);
      end
   end

   // Round-robin search starting after the last granted lane, gated by credits.
   always_comb begin
      w_found     = 1'b0;
      w_gidx      = '0;
      w_idx       = 0;
      w_can_issue = (int'(r_count) + w_inflight) < RSP_DEPTH;
      if (rst && !flush && w_can_issue) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
               w_found = 1'b1;
               w_gidx  = c_lane_w'(w_idx);
            end
         end
      end
   end

   assign req_ready      = w_found ? (NUM_REQ'(1) << w_gidx) : '0;
   assign eng_enable     = w_found;
   assign eng_prehash_t1 = w_found ? req_prehash[w_gidx*20 +: 10]      : 10'd0;
   assign eng_prehash_t2 = w_found ? req_prehash[w_gidx*20 + 10 +: 10] : 10'd0;
   assign w_win          = w_found ? req_window[w_gidx*WIN_W +: WIN_W]  : '0;
   assign w_cmp_out      = rst ? r_cmp_dly[CMP_DLY-1] : 48'd0;
   assign eng_fifo_in    = (w_win & ~c_cmp_mask) | ({{(WIN_W-48){1'b0}}, w_cmp_out} << 32);

   // Remember the last granted lane so the next search starts just after it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr <= c_lane_w'(NUM_REQ - 1);
      end else if (w_found) begin
         r_ptr <= w_gidx;
      end
   end

   // Delay the compare field so the compare stage sees its own lookup's window.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < CMP_DLY; i++) begin
            r_cmp_dly[i] <= 48'd0;
         end
      end else begin
         r_cmp_dly[0] <= w_win[79:32];
         for (int i = 1; i < CMP_DLY; i++) begin
            r_cmp_dly[i] <= r_cmp_dly[i-1];
         end
      end
   end

   // Track each issue through the engine latency; flush kills in-flight results.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_trk_vld <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_trk_lane[i] <= '0;
         end
      end else begin
         r_trk_vld     <= flush ? '0 : {r_trk_vld[LAT-2:0], w_found};
         r_trk_lane[0] <= w_gidx;
         for (int i = 1; i < LAT; i++) begin
            r_trk_lane[i] <= r_trk_lane[i-1];
         end
      end
   end

   assign w_push = r_trk_vld[LAT-1] && !flush;
   assign w_pop  = rsp_valid && rsp_ready && !flush;

   // Response storage; written when a tracked lookup leaves the engine.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {r_trk_lane[LAT-1], eng_compare_out, eng_suffix};
      end
   end

   // FIFO pointers and occupancy; flush empties the queue.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head     = r_mem[r_rd_ptr];
   assign rsp_valid  = rst && (r_count != '0);
   assign rsp_lane   = rsp_valid ? w_head[c_ent_w-1:4] : '0;
   assign rsp_match  = rsp_valid ? w_head[3:2]         : 2'd0;
   assign rsp_suffix = rsp_valid ? w_head[1:0]         : 2'd0;

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(w_push && !w_pop && (r_count == c_cnt_w'(RSP_DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_cuckoo_lookup_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cuckoo_lookup_sched
// Description : Directed, scoreboard-checked bench for cuckoo_lookup_sched
//               with a small fixed-latency engine model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cuckoo_lookup_sched;

   localparam int NUM_REQ   = 4;
   localparam int WIN_W     = 160;
   localparam int LAT       = 4;
   localparam int CMP_DLY   = 3;
   localparam int RSP_DEPTH = 8;
   localparam logic [47:0] KEY = 48'hA5A5_0000_1234;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic                     flush = 1'b0;
   logic                     rsp_ready = 1'b0;
   logic [NUM_REQ-1:0]       req_valid = '0;
   logic [NUM_REQ*20-1:0]    req_prehash = '0;
   logic [NUM_REQ*WIN_W-1:0] req_window = '0;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     eng_enable;
   logic [9:0]               eng_prehash_t1;
   logic [9:0]               eng_prehash_t2;
   logic [WIN_W-1:0]         eng_fifo_in;
   logic [1:0]               eng_compare_out;
   logic [1:0]               eng_suffix;
   logic                     rsp_valid;
   logic [1:0]               rsp_lane;
   logic [1:0]               rsp_match;
   logic [1:0]               rsp_suffix;

   cuckoo_lookup_sched #(
      .NUM_REQ(NUM_REQ), .WIN_W(WIN_W), .LAT(LAT), .CMP_DLY(CMP_DLY), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_prehash(req_prehash), .req_window(req_window),
      .req_ready(req_ready), .eng_enable(eng_enable),
      .eng_prehash_t1(eng_prehash_t1), .eng_prehash_t2(eng_prehash_t2),
      .eng_fifo_in(eng_fifo_in), .eng_compare_out(eng_compare_out), .eng_suffix(eng_suffix),
      .rsp_valid(rsp_valid), .rsp_lane(rsp_lane), .rsp_match(rsp_match),
      .rsp_suffix(rsp_suffix), .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;
   int key_lane = -1;
   logic [47:0] fld [NUM_REQ];

   typedef struct {
      int         lane;
      logic [3:0] res;
      int         icyc;
      bit         exact;
   } exp_t;
   exp_t scb[$];

   // Engine behaviour: {match[1:0], suffix[1:0]} derived from the compare field.
   function automatic logic [3:0] eng_fn(input logic [47:0] w);
      return {w == KEY, w[4] ^ w[0], w[9:8]};
   endfunction

   // Engine model: samples fifo_in[79:32] at CMP_DLY, answers at LAT.
   logic [47:0] e_reg;
   always @(posedge clk) e_reg <= eng_fifo_in[79:32];
   assign {eng_compare_out, eng_suffix} = eng_fn(e_reg);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock of stimulus, then checks of the combinational issue side.
   task automatic step(input logic [3:0] v, input bit rr, input bit fl, input bit rs,
                       input int el, input bit ex, input int erv);
      @(posedge clk);
      #1;
      req_valid = v;
      rsp_ready = rr;
      flush     = fl;
      rst       = rs;
      for (int l = 0; l < NUM_REQ; l++) begin
         fld[l] = (l == key_lane) ? KEY
                : {16'h0F0F, 16'(l * 257), 8'(cyc), 4'(l), 4'(cyc + l)};
         req_window[l*WIN_W +: WIN_W] = {72'h0, 8'(l + 8'h50), fld[l], 24'hC0DE00, 8'(16 * l + cyc % 16)};
         req_prehash[l*20 +: 20] = {10'(100 + l), 10'(l * 37 + cyc % 8)};
      end
      #3;
      chk("req_ready", 64'(req_ready), (el < 0) ? 64'd0 : (64'd1 << el));
      chk("eng_enable", 64'(eng_enable), 64'(el >= 0));
      if (el >= 0) begin
         chk("eng_prehash_t1", 64'(eng_prehash_t1), 64'(req_prehash[el*20 +: 10]));
         chk("eng_prehash_t2", 64'(eng_prehash_t2), 64'(req_prehash[el*20 + 10 +: 10]));
         chk("eng_fifo_lo", 64'(eng_fifo_in[31:0]), 64'(req_window[el*WIN_W +: 32]));
         chk("eng_fifo_hi", 64'(eng_fifo_in[127:80]), 64'(req_window[el*WIN_W + 80 +: 48]));
         scb.push_back('{lane: el, res: eng_fn(fld[el]), icyc: cyc, exact: ex});
      end
      if (erv >= 0) chk("rsp_valid", 64'(rsp_valid), 64'(erv));
      if (fl || !rs) scb.delete();
   endtask

   task automatic idle(input int n, input bit rr, input int erv);
      for (int i = 0; i < n; i++) step(4'b0000, rr, 1'b0, 1'b1, -1, 1'b0, erv);
   endtask

   // Monitor: every accepted response must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            if (scb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rsp_unexpected: actual lane=%0d match=%0h suffix=%0h required none (cycle %0d)",
                        rsp_lane, rsp_match, rsp_suffix, cyc);
            end else begin
               e = scb.pop_front();
               chk("rsp_lane", 64'(rsp_lane), 64'(e.lane));
               chk("rsp_result", 64'({rsp_match, rsp_suffix}), 64'(e.res));
               if (e.exact) chk("rsp_latency", 64'(cyc - e.icyc), 64'(LAT + 1));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset held with all lanes requesting: nothing may issue.
      for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0, 1'b0, -1, 1'b0, 0);

      // Round-robin fairness, first grant lane 0, sustained one per cycle.
      for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 1'b0, 1'b1, i % 4, 1'b1, -1);

      // Sparse requests wrap between lanes 0 and 3; idle inserts no issue.
      step(4'b1001, 1'b1, 1'b0, 1'b1, 0, 1'b1, -1);
      step(4'b1001, 1'b1, 1'b0, 1'b1, 3, 1'b1, -1);
      step(4'b1001, 1'b1, 1'b0, 1'b1, 0, 1'b1, -1);
      step(4'b1001, 1'b1, 1'b0, 1'b1, 3, 1'b1, -1);
      idle(8, 1'b1, -1);
      step(4'b0000, 1'b1, 1'b0, 1'b1, -1, 1'b0, 0);

      // Backpressure: exactly RSP_DEPTH issues, then single pops free one credit each.
      for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 1'b0, 1'b1, i % 4, 1'b0, -1);
      for (int i = 0; i < 6; i++) step(4'b1111, 1'b0, 1'b0, 1'b1, -1, 1'b0, -1);
      step(4'b1111, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1);
      step(4'b1111, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1);
      step(4'b1111, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1);
      step(4'b1111, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1);
      step(4'b1111, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1);
      step(4'b1111, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1);
      step(4'b1111, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1);
      idle(14, 1'b1, -1);
      step(4'b0000, 1'b1, 1'b0, 1'b1, -1, 1'b0, 0);

      // Alignment: only lane 2's lookup carries the key window.
      key_lane = 2;
      step(4'b1111, 1'b1, 1'b0, 1'b1, 2, 1'b1, -1);
      key_lane = -1;
      step(4'b1111, 1'b1, 1'b0, 1'b1, 3, 1'b1, -1);
      step(4'b1111, 1'b1, 1'b0, 1'b1, 0, 1'b1, -1);
      idle(7, 1'b1, -1);

      // Flush with three in flight and two buffered.
      step(4'b1111, 1'b0, 1'b0, 1'b1, 1, 1'b0, -1);
      step(4'b1111, 1'b0, 1'b0, 1'b1, 2, 1'b0, -1);
      step(4'b1111, 1'b0, 1'b0, 1'b1, 3, 1'b0, -1);
      step(4'b1111, 1'b0, 1'b0, 1'b1, 0, 1'b0, -1);
      step(4'b1111, 1'b0, 1'b0, 1'b1, 1, 1'b0, -1);
      step(4'b0000, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1);
      step(4'b1111, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1);
      idle(5, 1'b1, 0);
      step(4'b1111, 1'b1, 1'b0, 1'b1, 2, 1'b1, 0);
      step(4'b1111, 1'b1, 1'b0, 1'b1, 3, 1'b1, -1);
      step(4'b1111, 1'b1, 1'b0, 1'b1, 0, 1'b1, -1);
      idle(7, 1'b1, -1);
      step(4'b0000, 1'b1, 1'b0, 1'b1, -1, 1'b0, 0);

      // Reset mid-operation drops everything and restarts the pointer.
      step(4'b1111, 1'b1, 1'b0, 1'b1, 1, 1'b1, -1);
      step(4'b1111, 1'b1, 1'b0, 1'b1, 2, 1'b1, -1);
      step(4'b1111, 1'b1, 1'b0, 1'b0, -1, 1'b0, 0);
      step(4'b1111, 1'b1, 1'b0, 1'b0, -1, 1'b0, 0);
      idle(6, 1'b1, 0);
      step(4'b1111, 1'b1, 1'b0, 1'b1, 0, 1'b1, 0);
      idle(7, 1'b1, -1);
      step(4'b0000, 1'b1, 1'b0, 1'b1, -1, 1'b0, 0);

      chk("scb_empty", 64'(scb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
